bcd_display_ctrl: RTL and testbench

Sequential controller for the servo-angle readout. It accepts an 8-bit binary value on a load pulse and converts it to 3-digit BCD using shift-and-add-3, one bit per clock, with a busy/done handshake. It holds the result in a display register. It time-multiplexes the three digits onto a common-anode 7-segment display, with optional leading-zero blanking.

---
 rtl/bcd_display_ctrl.sv | 96 +++++++++
 tb/tb_bcd_display_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: serial binary-to-BCD converter with a multiplexed 7-segment display
module bcd_display_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [2:0]  an,
    output logic [6:0]  seg
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [7:0] sh;
    logic [11:0] scratch, adj, scr_n;
    logic [2:0] cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0] idx;
    logic [3:0] digit;
    logic blank, last;
    function automatic logic [3:0] adj3(input logic [3:0] n);
        return n > 4'd4 ? n + 4'd3 : n;
    endfunction
    assign adj = {adj3(scratch[11:8]), adj3(scratch[7:4]), adj3(scratch[3:0])};
    assign scr_n = {adj[10:0], sh[7]};
    assign last = state == SHIFT && cnt == 3'd7;
    assign busy = state == SHIFT;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && load) state_n = SHIFT;
        else if (last) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
            scratch <= '0;
            cnt <= '0;
            bcd <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (state == IDLE && load) begin
                sh <= value;
                scratch <= '0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                scratch <= scr_n;
                sh <= sh << 1;
                cnt <= cnt + 3'd1;
                if (last) bcd <= scr_n;
            end
        end
    end
    // digit scan runs freely, independent of conversion activity
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end
    assign an = ~(3'b001 << idx);
    assign digit = idx == 2'd0 ? bcd[3:0] : idx == 2'd1 ? bcd[7:4] : bcd[11:8];
    assign blank = BLANK_LZ && ((idx == 2'd2 && bcd[11:8] == 4'd0) ||
                                (idx == 2'd1 && bcd[11:4] == 8'd0));
    always_comb begin
        seg = 7'b1111111;
        if (!blank)
            case (digit)
                4'd0: seg = 7'b1000000;
                4'd1: seg = 7'b1111001;
                4'd2: seg = 7'b0100100;
                4'd3: seg = 7'b0110000;
                4'd4: seg = 7'b0011001;
                4'd5: seg = 7'b0010010;
                4'd6: seg = 7'b0000010;
                4'd7: seg = 7'b1111000;
                4'd8: seg = 7'b0000000;
                4'd9: seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
    end
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl: directed checks of conversion, handshake, reset abort and display scan
module tb_bcd_display_ctrl;
    logic clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [7:0] value = '0;
    logic busy, done, busy2, done2;
    logic [11:0] bcd, bcd2;
    logic [2:0] an, an2;
    logic [6:0] seg, seg2;
    int checks = 0, failures = 0, done_cnt = 0, dc;
    localparam logic [6:0] BL = 7'b1111111, S0 = 7'b1000000, S1 = 7'b1111001,
                           S5 = 7'b0010010, S9 = 7'b0010000;

    bcd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy),
        .done(done), .bcd(bcd), .an(an), .seg(seg));
    bcd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy2),
        .done(done2), .bcd(bcd2), .an(an2), .seg(seg2));

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // returns in the cycle where done is high, so a follow-on load is back-to-back
    task automatic convert(input logic [7:0] v, input logic [11:0] exp);
        int lat = 0, idle = 0;
        value = v;
        load = 1'b1;
        tick;
        load = 1'b0;
        while (!done && lat < 20) begin
            if (!busy) idle++;
            tick;
            lat++;
        end
        check("latency", lat, 8);
        check("busy_during", idle, 0);
        check("busy_end", busy, 0);
        check("bcd", bcd, exp);
    endtask

    task automatic disp(input string tag, input bit alt, input logic [6:0] e0,
                        input logic [6:0] e1, input logic [6:0] e2);
        logic [6:0] g0 = 'x, g1 = 'x, g2 = 'x;
        logic [2:0] a;
        logic [6:0] s;
        for (int i = 0; i < 15; i++) begin
            a = alt ? an2 : an;
            s = alt ? seg2 : seg;
            if (a == 3'b110) g0 = s;
            else if (a == 3'b101) g1 = s;
            else if (a == 3'b011) g2 = s;
            tick;
        end
        check({tag, "_ones"}, g0, e0);
        check({tag, "_tens"}, g1, e1);
        check({tag, "_hund"}, g2, e2);
    endtask

    logic [7:0] vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
    logic [11:0] exps [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};

    initial begin
        tick;
        tick;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_an", an, 3'b110);
        check("rst_seg", seg, S0);

        dc = done_cnt;
        convert(8'd255, 12'h255);
        tick;
        check("done_pulse", done, 0);
        check("done_once", done_cnt - dc, 1);

        for (int i = 0; i < 6; i++) convert(vals[i], exps[i]);
        convert(8'd9, 12'h009);
        tick;
        disp("v9", 1'b0, S9, BL, BL);
        convert(8'd100, 12'h100);
        tick;
        disp("v100", 1'b0, S0, S0, S1);
        convert(8'd5, 12'h005);
        tick;
        check("nb_bcd", bcd2, 12'h005);
        disp("v5_blank", 1'b0, S5, BL, BL);
        disp("v5_noblank", 1'b1, S5, S0, S0);

        dc = done_cnt;
        value = 8'd77;
        load = 1'b1;
        tick;
        load = 1'b0;
        tick;
        value = 8'd200;
        load = 1'b1;
        tick;
        load = 1'b0;
        tick;
        tick;
        load = 1'b1;
        tick;
        load = 1'b0;
        repeat (8) tick;
        check("ign_done", done_cnt - dc, 1);
        check("ign_bcd", bcd, 12'h077);
        check("ign_busy", busy, 0);

        dc = done_cnt;
        value = 8'd200;
        load = 1'b1;
        tick;
        load = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_bcd", bcd, 12'h000);
        repeat (10) tick;
        check("abort_nodone", done_cnt - dc, 0);
        convert(8'd42, 12'h042);
        tick;

        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int j = 0; j < 24; j++) begin
            check($sformatf("scan%0d", j), an, 3'b111 ^ (3'b001 << ((j / 4) % 3)));
            tick;
        end
        dc = done_cnt;
        convert(8'd150, 12'h150);
        convert(8'd61, 12'h061);
        tick;
        check("b2b_done", done_cnt - dc, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
